// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default sizing parameters.
package mac_pkg;

  localparam int ACC_W_DEFAULT = 12;
  localparam int BATCH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_EMIT_LO = 2'd1,
    ST_EMIT_HI = 2'd2
  } mac_state_t;

  // High result byte: sticky overflow flag on top, upper accumulator bits below.
  function automatic logic [7:0] pack_hi(input logic ovf_bit, input logic [6:0] acc_hi);
    return {ovf_bit, acc_hi};
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums BATCH unsigned 8-bit products into an ACC_W-bit accumulator and emits
// each result as two bytes (low first) with a sticky overflow flag.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int BATCH = BATCH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [7:0] in_prod,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int CNT_W = $clog2(BATCH);

  mac_state_t       state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  logic [ACC_W:0]   sum;
  logic [6:0]       acc_hi;
  logic             last_prod;

  // One extra bit on the adder exposes the carry that feeds the sticky flag.
  assign sum       = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, in_prod};
  assign acc_hi    = 7'(acc_reg >> 8);
  assign last_prod = (cnt_reg == CNT_W'(BATCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      state_reg <= ST_ACCUM;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (in_valid) begin
            acc_reg <= sum[ACC_W-1:0];
            cnt_reg <= cnt_reg + CNT_W'(1);
            busy    <= 1'b1;
            if (sum[ACC_W]) begin
              ovf_reg <= 1'b1;
            end
            if (last_prod) begin
              // Low byte comes straight from the adder so it is valid on entry.
              state_reg <= ST_EMIT_LO;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= sum[7:0];
              out_last  <= 1'b0;
            end
          end
        end
        ST_EMIT_LO: begin
          if (out_ready) begin
            state_reg <= ST_EMIT_HI;
            out_data  <= pack_hi(ovf_reg, acc_hi);
            out_last  <= 1'b1;
          end
        end
        ST_EMIT_HI: begin
          if (out_ready) begin
            state_reg <= ST_ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_ACCUM;
          acc_reg   <= '0;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= 8'h00;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus a BATCH=20
// instance for the overflow case.
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;

  logic       a_clr, a_in_valid, a_out_ready;
  logic [7:0] a_in_prod;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [7:0] a_out_data;

  logic       b_clr, b_in_valid, b_out_ready;
  logic [7:0] b_in_prod;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [7:0] b_out_data;

  int total;
  int bad;

  product_accumulator dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (a_clr),
    .in_valid  (a_in_valid),
    .in_prod   (a_in_prod),
    .in_ready  (a_in_ready),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_last  (a_out_last),
    .busy      (a_busy)
  );

  product_accumulator #(.ACC_W(12), .BATCH(20)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (b_clr),
    .in_valid  (b_in_valid),
    .in_prod   (b_in_prod),
    .in_ready  (b_in_ready),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_out(input string tag, input logic [7:0] data, input logic last);
    chk({tag, "_valid"}, 16'(a_out_valid), 16'h1);
    chk({tag, "_data"}, 16'(a_out_data), 16'(data));
    chk({tag, "_last"}, 16'(a_out_last), 16'(last));
    chk({tag, "_inrdy"}, 16'(a_in_ready), 16'h0);
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_valid"}, 16'(a_out_valid), 16'h0);
    chk({tag, "_data"}, 16'(a_out_data), 16'h0);
    chk({tag, "_inrdy"}, 16'(a_in_ready), 16'h1);
    chk({tag, "_busy"}, 16'(a_busy), 16'h0);
  endtask

  task automatic push_a(input logic [7:0] prod, input int n);
    a_in_valid = 1'b1;
    a_in_prod  = prod;
    repeat (n) step();
    a_in_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] prod, input int n);
    b_in_valid = 1'b1;
    b_in_prod  = prod;
    repeat (n) step();
    b_in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_clr = 1'b0; a_in_valid = 1'b0; a_in_prod = 8'h00; a_out_ready = 1'b1;
    b_clr = 1'b0; b_in_valid = 1'b0; b_in_prod = 8'h00; b_out_ready = 1'b1;

    #12;
    chk_a_idle("rst");
    chk("rst_last", 16'(a_out_last), 16'h0);
    chk("rst_b_valid", 16'(b_out_valid), 16'h0);
    rst_n = 1'b1;
    step();

    // Four products of 225 = 900 = 0x384.
    push_a(8'd225, 4);
    chk_a_out("t1_lo", 8'h84, 1'b0);
    step();
    chk_a_out("t1_hi", 8'h03, 1'b1);
    step();
    chk_a_idle("t1_end");

    // Same batch with a 3-cycle stall on the low byte; extra inputs must be refused.
    a_out_ready = 1'b0;
    push_a(8'd225, 4);
    a_in_valid = 1'b1;
    a_in_prod  = 8'd1;
    for (int i = 0; i < 3; i++) begin
      chk_a_out($sformatf("t2_stall%0d", i), 8'h84, 1'b0);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    chk_a_out("t2_lo", 8'h84, 1'b0);
    step();
    chk_a_out("t2_hi", 8'h03, 1'b1);
    step();
    chk_a_idle("t2_end");

    // Partial batch aborted by clr, including a same-cycle input that is dropped.
    push_a(8'd100, 2);
    chk("t3_busy_mid", 16'(a_busy), 16'h1);
    a_clr      = 1'b1;
    a_in_valid = 1'b1;
    a_in_prod  = 8'd100;
    step();
    a_clr      = 1'b0;
    a_in_valid = 1'b0;
    chk_a_idle("t3_clr");
    for (int i = 0; i < 4; i++) begin
      step();
      push_a(8'd1, 1);
    end
    chk_a_out("t3_lo", 8'h04, 1'b0);
    step();
    chk_a_out("t3_hi", 8'h00, 1'b1);
    step();
    chk_a_idle("t3_end");

    // Reset pulse while the high byte is on the bus.
    push_a(8'd50, 4);
    chk_a_out("t4_lo", 8'hC8, 1'b0);
    step();
    chk_a_out("t4_hi", 8'h00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_idle("t4_rst");
    chk("t4_rst_last", 16'(a_out_last), 16'h0);
    #2;
    rst_n = 1'b1;
    step();
    push_a(8'd2, 4);
    chk_a_out("t4_lo2", 8'h08, 1'b0);
    step();
    chk_a_out("t4_hi2", 8'h00, 1'b1);
    step();
    chk_a_idle("t4_end");

    // BATCH=20: 20*225 = 4500 wraps to 0x194 with overflow set.
    push_b(8'd225, 19);
    chk("t5_b_valid19", 16'(b_out_valid), 16'h0);
    chk("t5_b_busy19", 16'(b_busy), 16'h1);
    push_b(8'd225, 1);
    chk("t5_b_lo_valid", 16'(b_out_valid), 16'h1);
    chk("t5_b_lo", 16'(b_out_data), 16'h94);
    step();
    chk("t5_b_hi", 16'(b_out_data), 16'h81);
    chk("t5_b_hi_last", 16'(b_out_last), 16'h1);
    step();
    chk("t5_b_busy_end", 16'(b_busy), 16'h0);
    push_b(8'd1, 20);
    chk("t5_b_lo2", 16'(b_out_data), 16'h14);
    step();
    chk("t5_b_hi2", 16'(b_out_data), 16'h00);
    chk("t5_b_hi2_last", 16'(b_out_last), 16'h1);
    step();
    chk("t5_b_valid_end", 16'(b_out_valid), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter ACC_W, default 12: accumulator width, legal range 9..15.
REQ-002 Parameter BATCH, default 4: products summed per result, legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous clear; aborts the current batch or emission.
REQ-006 in_valid  input  1  in_prod holds a valid product.
REQ-007 in_prod  input  8  unsigned 4x4 product from the array multiplier stage.
REQ-008 in_ready  output  1  block accepts a product this cycle.
REQ-009 out_valid  output  1  out_data holds a valid result byte.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  8  result byte, low byte first.
REQ-012 out_last  output  1  marks the second (final) byte of a result.
REQ-013 busy  output  1  high when the batch count is nonzero or a result is being emitted.

Function
REQ-014 States SHALL be ACCUM, EMIT_LO and EMIT_HI.
REQ-015 ACCUM: in_ready=1 and out_valid=0; EMIT_LO/EMIT_HI: in_ready=0 and out_valid=1.
REQ-016 Input transfer is in_valid&in_ready: acc <= acc + zero-extended in_prod, modulo 2^ACC_W; cnt <= cnt+1.
REQ-017 A carry out of bit ACC_W-1 on any transfer SHALL set the sticky flag ovf.
REQ-018 A transfer with cnt==BATCH-1 SHALL move the block to EMIT_LO on the next edge (latency: last product at edge t, out_valid high after edge t).
REQ-019 EMIT_LO: out_data=acc[7:0], out_last=0; on out_ready -> EMIT_HI.
REQ-020 EMIT_HI: out_data={ovf, zeros, acc[ACC_W-1:8]}, out_last=1; on out_ready -> ACCUM with acc, cnt and ovf cleared on the same edge.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-022 Cycles with in_valid=0 in ACCUM SHALL leave acc, cnt and ovf unchanged.
REQ-023 clr SHALL take priority over every transfer: next state ACCUM, acc=0, cnt=0, ovf=0, and any in-flight input or output transfer that cycle is discarded.
REQ-024 in_ready, out_valid, out_data, out_last and busy SHALL be driven from registers or decoded state only, with no combinational path from in_valid or out_ready.
REQ-025 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force ACCUM, acc=0, cnt=0, ovf=0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-027 Reset asserted mid-batch or mid-emission SHALL discard the partial result; the first transfer after release starts a new batch.

Structure
REQ-028 Package mac_pkg SHALL hold the state enum and the ACC_W/BATCH defaults.
REQ-029 Single module with no sub-module; the adder and counter are inline and cnt is ceil(log2(BATCH)) bits wide.

Verification
REQ-030 Default parameters, four products of 225 back-to-back, out_ready=1 -> bytes 0x84 then 0x03 (out_last=1), busy low afterwards.
REQ-031 Same stimulus with out_ready low for 3 cycles in EMIT_LO -> 0x84 held stable, in_ready=0 throughout, then 0x84 and 0x03 delivered once each.
REQ-032 BATCH=20, twenty products of 225 -> 4500 mod 4096 = 0x194, giving bytes 0x94 then 0x81 (ovf bit set); the next batch shows ovf=0.
REQ-033 Two products of 100, then clr, then four products of 1 with in_valid gaps -> bytes 0x04 then 0x00.
REQ-034 rst_n pulsed low during EMIT_HI -> out_valid=0 and in_ready=1 immediately; four products of 2 then yield 0x08 then 0x00.
